// File: rtl/rep_seq_ctrl_pkg.sv
// rep_seq_pkg: shared types and constants for the repeated-value sequence
// controller (value v emitted v times: 1,2,2,3,3,3,...).
package rep_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rep_seq_state_e;

    localparam int W_DEF     = 6;
    localparam int BW_DEF    = 12;
    localparam int SEQ_FIRST = 1;

endpackage

// File: rtl/rep_seq_ctrl_if.sv
// rep_seq_ctrl_if: valid/ready output stream carrying the current value and
// its repetition index. The controller is the master, the consumer the slave.
interface rep_seq_ctrl_if #(
    parameter int W = 6
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic [W-1:0] rep_idx;

    modport master (
        output out_valid,
        output out_value,
        output rep_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  rep_idx,
        output out_ready
    );
endinterface

// File: rtl/rep_seq_core.sv
// rep_seq_core: curr/rep register pair of the sequence. rep counts 1..curr;
// when rep reaches curr the value steps up until it reaches the limit.
// On the final beat an advance holds the pair; the caller decides whether
// to reload (wrap) or to stop.
module rep_seq_core
    import rep_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_first_i,
    input  logic         advance_i,
    input  logic [W-1:0] lim_i,
    output logic [W-1:0] curr_o,
    output logic [W-1:0] rep_o,
    output logic         last_beat_o
);

    localparam logic [W-1:0] ONE  = W'(SEQ_FIRST);
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] curr_q;
    logic [W-1:0] rep_q;

    // Sequence state update; clear beats load, load beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curr_q <= ZERO;
            rep_q  <= ZERO;
        end else if (clear_i) begin
            curr_q <= ZERO;
            rep_q  <= ZERO;
        end else if (load_first_i) begin
            curr_q <= ONE;
            rep_q  <= ONE;
        end else if (advance_i) begin
            if (rep_q != curr_q) begin
                rep_q <= rep_q + ONE;
            end else if (curr_q != lim_i) begin
                curr_q <= curr_q + ONE;
                rep_q  <= ONE;
            end else begin
                curr_q <= curr_q;
                rep_q  <= rep_q;
            end
        end else begin
            curr_q <= curr_q;
            rep_q  <= rep_q;
        end
    end

    assign curr_o      = curr_q;
    assign rep_o       = rep_q;
    assign last_beat_o = (rep_q == curr_q) && (curr_q == lim_i);

endmodule

// File: rtl/rep_seq_ctrl.sv
// rep_seq_ctrl: start/stop sequencing, programmable limit, valid/ready
// output handshake, completion status and beat counter around rep_seq_core.
// Optional feature macro: REP_SEQ_WRAP_EN -- restart at 1 after the last
// beat instead of entering DONE; done then pulses once per pass.
module rep_seq_ctrl
    import rep_seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int BW = 2 * W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [W-1:0]         limit,
    rep_seq_ctrl_if.master       out,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [BW-1:0]        beat_cnt
);

    localparam logic [BW-1:0] BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BEAT_ZERO = {BW{1'b0}};
    localparam logic [W-1:0]  LIM_ZERO  = {W{1'b0}};

    rep_seq_state_e state_q;
    logic [W-1:0]   lim_q;
    logic [BW-1:0]  beat_cnt_q;
    logic           out_valid_q;
    logic           busy_q;
    logic           done_q;
    logic           cfg_err_q;

    logic [W-1:0]   curr_s;
    logic [W-1:0]   rep_s;
    logic           last_beat_s;
    logic           xfer_s;
    logic           idle_or_done_s;
    logic           start_ok_s;
    logic           wrap_load_s;

    assign xfer_s         = out_valid_q & out.out_ready;
    assign idle_or_done_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_ok_s     = idle_or_done_s & start & ~stop & (limit != LIM_ZERO);
`ifdef REP_SEQ_WRAP_EN
    assign wrap_load_s    = (state_q == ST_RUN) & xfer_s & last_beat_s & ~stop;
`else
    assign wrap_load_s    = 1'b0;
`endif

    rep_seq_core #(.W(W)) u_core (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (stop),
        .load_first_i (start_ok_s | wrap_load_s),
        .advance_i    ((state_q == ST_RUN) & xfer_s),
        .lim_i        (lim_q),
        .curr_o       (curr_s),
        .rep_o        (rep_s),
        .last_beat_o  (last_beat_s)
    );

    // Control FSM with registered handshake, status and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lim_q       <= LIM_ZERO;
            beat_cnt_q  <= BEAT_ZERO;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
`ifdef REP_SEQ_WRAP_EN
            done_q    <= 1'b0;
`endif
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (stop) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                    end else if (start && (limit != LIM_ZERO)) begin
                        state_q     <= ST_RUN;
                        lim_q       <= limit;
                        beat_cnt_q  <= BEAT_ZERO;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end else if (start) begin
                        cfg_err_q <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                    end
                    if (stop) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                    end else if (xfer_s && last_beat_s) begin
`ifdef REP_SEQ_WRAP_EN
                        done_q      <= 1'b1;
`else
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
`endif
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out.out_valid = out_valid_q;
    assign out.out_value = curr_s;
    assign out.rep_idx   = rep_s;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign beat_cnt      = beat_cnt_q;

endmodule

// File: doc/rep_seq_ctrl.md
Name: rep_seq_ctrl

Overview:
- Sequencing controller for the "value v emitted v times" pattern generator (1,2,2,3,3,3,...).
- Adds what the bare counter lacks:
  - start/stop control and a programmable upper limit;
  - valid/ready output handshake with backpressure;
  - completion status and a beat counter.
- Sits between the control/config logic and any downstream consumer of the pattern stream.

Parameters:
- W, 6, width of value, limit and repetition index.
- BW, 2*W, width of the beat counter; holds L(L+1)/2 for L = 2^W-1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sequence; sampled in IDLE or DONE only.
- stop  input  1  abort to IDLE; sampled in any state.
- limit  input  W  highest value to emit; captured on accepted start.
- out_ready  input  1  consumer accepts the current beat.
- out_valid  output  1  beat available.
- out_value  output  W  current value v.
- rep_idx  output  W  repetition number of v, 1..v.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- cfg_err  output  1  one-cycle pulse when start is given with limit == 0.
- beat_cnt  output  BW  beats transferred since the last accepted start.

Behaviour:
- Reset (asynchronous, active-high rst): state IDLE.
  - All outputs are 0: out_valid, out_value, rep_idx, busy, done, cfg_err, beat_cnt.
  - Internal lim_q is cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start=1, limit != 0:
  - Capture lim_q <= limit; curr <= 1; rep <= 1; beat_cnt <= 0.
  - Go to RUN; done clears.
  - out_valid rises the next cycle with out_value=1, rep_idx=1.
- IDLE/DONE, start=1, limit == 0:
  - cfg_err pulses for 1 cycle; state and all other outputs are unchanged.
- RUN:
  - out_valid=1, out_value=curr, rep_idx=rep.
  - A transfer is out_valid & out_ready. On a transfer, beat_cnt increments.
  - Transfer with rep != curr: rep <= rep+1.
  - Transfer with rep == curr and curr != lim_q: curr <= curr+1, rep <= 1.
  - Transfer with rep == curr and curr == lim_q: go to DONE; out_valid drops next cycle.
- Backpressure: while out_ready=0, out_value, rep_idx and out_valid are held stable. The only exception is stop.
- start in RUN is ignored. limit changes after capture are ignored.
- stop (any state) wins over start:
  - Next state is IDLE; out_valid, busy and done go 0.
  - out_value and rep_idx are cleared to 0; beat_cnt holds its value.
  - stop coincident with a transfer: the transfer counts (beat_cnt increments), then the block goes to IDLE.
- DONE:
  - done=1 and out_value holds the last value.
  - Stays here until start (restart) or stop (go to IDLE).
- Total beats per pass = L(L+1)/2. No arithmetic wraps within a pass: curr never exceeds lim_q ≤ 2^W-1.
- An asynchronous rst in the middle of RUN forces the reset state immediately; no beat is in flight afterwards.

Optional Feature:
- Macro: REP_SEQ_WRAP_EN.
- Defined:
  - On the final transfer (curr == lim_q, rep == curr) the block stays in RUN and restarts at curr=1, rep=1 with no bubble cycle.
  - done pulses for 1 cycle per completed pass; DONE is never entered.
  - beat_cnt wraps modulo 2^BW.
- Undefined: the block stops in DONE as described in Behaviour.

Decomposition:
- Package rep_seq_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default widths W_DEF=6 and BW_DEF=12;
  - constant SEQ_FIRST=1.
- Sub-module rep_seq_core: curr/rep register pair.
  - Inputs: advance enable, load-first, lim_q.
  - Outputs: curr, rep, last_beat (rep == curr && curr == lim_q).
  - The top holds the FSM, handshake and beat_cnt.

Test Plan:
- limit=3, out_ready=1 constant, start pulse → values 1,2,2,3,3,3 and rep_idx 1,1,2,1,2,3 on 6 consecutive cycles; then done=1, out_valid=0, beat_cnt=6.
- limit=3, out_ready toggled 1,0,0,1,... → at most one transfer per ready cycle; value and rep_idx stable during stalls; same 6-beat stream; beat_cnt=6.
- limit=0 with start → cfg_err high exactly 1 cycle; state stays IDLE; out_valid=0.
- limit=4, stop asserted together with the 3rd transfer → beat_cnt=3; out_valid=0 and state IDLE next cycle; a new start with limit=2 yields 1,2,2.
- rst asserted asynchronously mid-RUN (limit=5, after 7 beats) → all outputs 0 immediately, before the next clk edge.
- With REP_SEQ_WRAP_EN, limit=2, ready=1 → stream 1,2,2,1,2,2,...; done pulses on the cycle after each third beat; busy stays 1.
